// File: rtl/ex_stage_fwd_md.sv
// Execute stage for the DLX pipeline. It forwards operands from MEM and WB,
// detects load-use hazards and stalls on them, and turns invalid, flushed or
// stalled slots into bubbles. An optional iterative unsigned multiply/divide
// unit holds the front end while it works. The stage owns the EX/MEM register.
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   valid_EX, flush_EX              instruction valid / kill request for EX
//   I_EX, md_op_EX                  ALU opcode / multiply-divide opcode
//   Pc_alu_EX, Iv_alu_EX            operand selects (PC for op1, immediate for op2)
//   Pc_add_EX, Pc_cmd_ex_EX         branch target select / conditional redirect
//   d_write_enable_EX, d_load_enable_EX   memory controls carried to MEM
//   Rd_EX, Rs1_EX, Rs2_EX           register indices
//   Iv_EX, S1_EX, S2_EX, PC_EX      immediate, register values, PC
//   *_MEM_backward, *_WB_backward   forwarding sources from MEM and WB
//   stall_EX, pc_cmd_EX, pc_in_EX   hazard hold, redirect request and target
//   ALU_out_MEM ... valid_MEM       EX/MEM pipeline register
module ex_stage_fwd_md #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned MD_EN  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_EX,
  input  logic              flush_EX,
  input  logic [OP_W-1:0]   I_EX,
  input  logic [1:0]        md_op_EX,
  input  logic              Pc_alu_EX,
  input  logic              Iv_alu_EX,
  input  logic              Pc_add_EX,
  input  logic              Pc_cmd_ex_EX,
  input  logic              d_write_enable_EX,
  input  logic              d_load_enable_EX,
  input  logic [REG_AW-1:0] Rd_EX,
  input  logic [REG_AW-1:0] Rs1_EX,
  input  logic [REG_AW-1:0] Rs2_EX,
  input  logic [XLEN-1:0]   Iv_EX,
  input  logic [XLEN-1:0]   S1_EX,
  input  logic [XLEN-1:0]   S2_EX,
  input  logic [XLEN-1:0]   PC_EX,
  input  logic [XLEN-1:0]   ALU_out_MEM_backward,
  input  logic [REG_AW-1:0] Rd_MEM_backward,
  input  logic              load_MEM_backward,
  input  logic [XLEN-1:0]   ALU_out_WB_backward,
  input  logic [REG_AW-1:0] Rd_WB_backward,
  output logic              stall_EX,
  output logic              pc_cmd_EX,
  output logic [XLEN-1:0]   pc_in_EX,
  output logic [XLEN-1:0]   ALU_out_MEM,
  output logic [XLEN-1:0]   S2_MEM,
  output logic [REG_AW-1:0] Rd_MEM,
  output logic [REG_AW-1:0] Rs2_MEM,
  output logic              d_write_enable_MEM,
  output logic              d_load_enable_MEM,
  output logic              valid_MEM
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned SH_W  = $clog2(XLEN);

  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_AND  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_OR   = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_SLT  = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_SLTU = OP_W'(9);

  localparam logic [1:0] MD_MUL  = 2'b01;
  localparam logic [1:0] MD_DIVU = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t state, state_nxt;

  logic [XLEN-1:0]   fwd1, fwd2, op1, op2, alu_res;
  logic              zf, load_use, md_issue;

  logic [1:0]        md_op;
  logic [XLEN-1:0]   md_a, md_b, md_acc, md_s2, md_result;
  logic [CNT_W-1:0]  md_cnt;
  logic [REG_AW-1:0] md_rd, md_rs2;
  logic              md_we, md_le;
  logic [XLEN:0]     rem_shift;
  logic [XLEN-1:0]   rem_diff;
  logic              div_ge;

  // Operand forwarding: MEM (non-load) beats WB beats the register file; r0 never forwards.
  always_comb begin
    fwd1 = S1_EX;
    fwd2 = S2_EX;
    if (Rs1_EX != '0 && Rs1_EX == Rd_MEM_backward && !load_MEM_backward)
      fwd1 = ALU_out_MEM_backward;
    else if (Rs1_EX != '0 && Rs1_EX == Rd_WB_backward)
      fwd1 = ALU_out_WB_backward;
    if (Rs2_EX != '0 && Rs2_EX == Rd_MEM_backward && !load_MEM_backward)
      fwd2 = ALU_out_MEM_backward;
    else if (Rs2_EX != '0 && Rs2_EX == Rd_WB_backward)
      fwd2 = ALU_out_WB_backward;
  end

  assign op1 = Pc_alu_EX ? PC_EX : fwd1;
  assign op2 = Iv_alu_EX ? Iv_EX : fwd2;

  // ALU
  always_comb begin
    alu_res = op2;
    case (I_EX)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_AND:  alu_res = op1 & op2;
      ALU_OR:   alu_res = op1 | op2;
      ALU_XOR:  alu_res = op1 ^ op2;
      ALU_SLL:  alu_res = op1 << op2[SH_W-1:0];
      ALU_SRL:  alu_res = op1 >> op2[SH_W-1:0];
      ALU_SRA:  alu_res = $unsigned($signed(op1) >>> op2[SH_W-1:0]);
      ALU_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
      ALU_SLTU: alu_res = XLEN'(op1 < op2);
      default:  alu_res = op2;
    endcase
  end
  assign zf = (alu_res == '0);

  // Load-use: the loaded value is not available until WB, so hold EX one cycle.
  assign load_use = valid_EX && load_MEM_backward &&
                    ((Rs1_EX != '0 && Rs1_EX == Rd_MEM_backward) ||
                     (Rs2_EX != '0 && Rs2_EX == Rd_MEM_backward));

  assign md_issue = valid_EX && (MD_EN != 0) && (md_op_EX != 2'b00) && !load_use && !flush_EX;

  // MD FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MD_IDLE;
    else          state <= state_nxt;
  end

  // MD FSM next state and stall
  always_comb begin
    state_nxt = state;
    stall_EX  = 1'b0;
    case (state)
      MD_IDLE: begin
        if (load_use) begin
          stall_EX = 1'b1;
        end else if (md_issue) begin
          stall_EX  = 1'b1;
          state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (flush_EX) begin
          state_nxt = MD_IDLE;
        end else begin
          stall_EX = 1'b1;
          if (md_cnt == CNT_W'(1)) state_nxt = MD_DONE;
        end
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    // Hold requests low while reset is asserted.
    if (!reset_n) stall_EX = 1'b0;
  end

  // Restoring-divide step: md_a shifts the dividend out and the quotient in.
  always_comb begin
    rem_shift = {md_acc, md_a[XLEN-1]};
    div_ge    = (rem_shift >= {1'b0, md_b});
    rem_diff  = rem_shift[XLEN-1:0] - md_b;
  end

  // MUL leaves the product in md_acc, DIVU the quotient in md_a, REMU the remainder in md_acc.
  assign md_result = (md_op == MD_DIVU) ? md_a : md_acc;

  // MD datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_op  <= '0;
      md_a   <= '0;
      md_b   <= '0;
      md_acc <= '0;
      md_s2  <= '0;
      md_cnt <= '0;
      md_rd  <= '0;
      md_rs2 <= '0;
      md_we  <= 1'b0;
      md_le  <= 1'b0;
    end else if (state == MD_IDLE && md_issue) begin
      md_op  <= md_op_EX;
      md_a   <= fwd1;
      md_b   <= fwd2;
      md_acc <= '0;
      md_s2  <= fwd2;
      md_cnt <= CNT_W'(XLEN);
      md_rd  <= Rd_EX;
      md_rs2 <= Rs2_EX;
      md_we  <= d_write_enable_EX;
      md_le  <= d_load_enable_EX;
    end else if (state == MD_BUSY && !flush_EX) begin
      md_cnt <= md_cnt - CNT_W'(1);
      if (md_op == MD_MUL) begin
        md_acc <= md_acc + (md_b[0] ? md_a : '0);
        md_a   <= md_a << 1;
        md_b   <= md_b >> 1;
      end else begin
        md_acc <= div_ge ? rem_diff : rem_shift[XLEN-1:0];
        md_a   <= {md_a[XLEN-2:0], div_ge};
      end
    end
  end

  // Branch redirect
  assign pc_in_EX  = Pc_add_EX ? (PC_EX + Iv_EX) : fwd1;
  assign pc_cmd_EX = reset_n && valid_EX && !flush_EX && !stall_EX && Pc_cmd_ex_EX && zf;

  // EX/MEM register: MD result on completion, bubble on invalid/flush/stall, else ALU result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ALU_out_MEM        <= '0;
      S2_MEM             <= '0;
      Rd_MEM             <= '0;
      Rs2_MEM            <= '0;
      d_write_enable_MEM <= 1'b0;
      d_load_enable_MEM  <= 1'b0;
      valid_MEM          <= 1'b0;
    end else if (state == MD_DONE && !flush_EX) begin
      ALU_out_MEM        <= md_result;
      S2_MEM             <= md_s2;
      Rd_MEM             <= md_rd;
      Rs2_MEM            <= md_rs2;
      d_write_enable_MEM <= md_we;
      d_load_enable_MEM  <= md_le;
      valid_MEM          <= 1'b1;
    end else if (!valid_EX || flush_EX || stall_EX) begin
      ALU_out_MEM        <= '0;
      S2_MEM             <= '0;
      Rd_MEM             <= '0;
      Rs2_MEM            <= '0;
      d_write_enable_MEM <= 1'b0;
      d_load_enable_MEM  <= 1'b0;
      valid_MEM          <= 1'b0;
    end else begin
      ALU_out_MEM        <= alu_res;
      S2_MEM             <= fwd2;
      Rd_MEM             <= Rd_EX;
      Rs2_MEM            <= Rs2_EX;
      d_write_enable_MEM <= d_write_enable_EX;
      d_load_enable_MEM  <= d_load_enable_EX;
      valid_MEM          <= 1'b1;
    end
  end

endmodule
